multicycle_control: RTL and testbench

- Control FSM that sequences a shared multi-cycle MIPS datapath: one memory, one ALU, PC/IR registers.
- Supported instructions: R-type, lw, sw, addi, beq, j, jal, slti.
- Drives mux selects and write enables each state, and waits on a memory ready handshake.
- A wait timer catches a memory that never responds and latches a fault.

---
 rtl/multicycle_pkg.sv | 74 +++++++
 rtl/multicycle_wait_timer.sv | 42 ++++
 rtl/multicycle_control.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state codes,
// opcodes, datapath select encodings and the control-word bundle.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_JAL     = 4'd10,
        S_IMMEXEC = 4'd11,
        S_IMMWB   = 4'd12,
        S_HALT    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_SLT   = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
    localparam logic [1:0] MEMTOREG_PC     = 2'b10;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic [1:0] regDst;
        logic [1:0] memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    // States that hold a memory access open and are therefore timed.
    function automatic logic isWaitState(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the
// cycle in which the limit is hit without the memory answering.
module multicycle_wait_timer
    import multicycle_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic start,
    input  logic ready,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // start holds the count at zero until an access is in flight, so every
    // wait state is entered with a fresh count.
    always_comb begin
        count_d = count_q;
        if (start || ready) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = !start && !ready && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for a shared multi-cycle MIPS datapath, with a memory
// wait timer that parks the machine in HALT when memory stops answering.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Fault,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_d;
    logic   fault_q;
    logic   fault_d;
    logic   timeout;
    ctrl_t  ctrl;

    multicycle_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .CNT_W     (CNT_W)
    ) u_wait_timer (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .start  (!isWaitState(state_q)),
        .ready  (MemReady),
        .timeout(timeout)
    );

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    OP_ADDI, OP_SLTI: state_d = S_IMMEXEC;
                    default:          state_d = S_EXEC;
                endcase
            end
            S_MEMADR:  state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (MemReady) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_MEMWR: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_EXEC:    state_d = S_RTYPEWB;
            S_IMMEXEC: state_d = S_IMMWB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    // Moore decode of the state register; only the FETCH load strobes
    // follow MemReady so PC and IR capture on the completing edge.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = ALUSRCB_FOUR;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = PCSRC_ALU;
                ctrl.irWrite  = MemReady;
                ctrl.pcWrite  = MemReady;
            end
            S_DECODE: begin
                ctrl.aluSrcB = ALUSRCB_IMMSH;
                ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = ALUSRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iorD    = 1'b1;
                ctrl.memRead = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regDst   = REGDST_RT;
                ctrl.memtoReg = MEMTOREG_MDR;
                ctrl.regWrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iorD     = 1'b1;
                ctrl.memWrite = 1'b1;
            end
            S_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = ALUSRCB_B;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regDst   = REGDST_RD;
                ctrl.memtoReg = MEMTOREG_ALUOUT;
                ctrl.regWrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = ALUSRCB_B;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            S_JAL: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
                ctrl.regDst   = REGDST_RA;
                ctrl.memtoReg = MEMTOREG_PC;
                ctrl.regWrite = 1'b1;
            end
            S_IMMEXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = ALUSRCB_IMM;
                ctrl.aluOp   = (Opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_IMMWB: begin
                ctrl.regDst   = REGDST_RT;
                ctrl.memtoReg = MEMTOREG_ALUOUT;
                ctrl.regWrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (!Reset_n) begin
            ctrl = '0;
        end
    end

    assign PCWrite     = ctrl.pcWrite;
    assign PCWriteCond = ctrl.pcWriteCond;
    assign IorD        = ctrl.iorD;
    assign MemRead     = ctrl.memRead;
    assign MemWrite    = ctrl.memWrite;
    assign IRWrite     = ctrl.irWrite;
    assign RegDst      = ctrl.regDst;
    assign MemtoReg    = ctrl.memtoReg;
    assign RegWrite    = ctrl.regWrite;
    assign ALUSrcA     = ctrl.aluSrcA;
    assign ALUSrcB     = ctrl.aluSrcB;
    assign ALUOp       = ctrl.aluOp;
    assign PCSource    = ctrl.pcSource;
    assign Fault       = fault_q;
    assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected control words are queued
// as each cycle is driven and compared against the DUT on the falling edge.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic [1:0] regDst;
        logic [1:0] memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       fault;
        logic [3:0] state;
    } obs_t;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] RegDst, MemtoReg;
    logic       RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       Fault;
    logic [3:0] State;

    int    assertions = 0;
    int    failures   = 0;
    obs_t  expQ[$];
    string tagQ[$];

    multicycle_control #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Opcode     (Opcode),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .Fault      (Fault),
        .State      (State)
    );

    always #5 Clk = ~Clk;

    // Reference control word for one cycle, written from the state table.
    function automatic obs_t expCtrl(input logic [3:0] st, input logic [5:0] op,
                                     input logic rdy, input logic flt);
        obs_t e;
        e = '0;
        case (st)
            4'd0: begin
                e.memRead = 1'b1; e.aluSrcB = 2'b01; e.aluOp = 2'b11;
                e.irWrite = rdy;  e.pcWrite = rdy;
            end
            4'd1: begin e.aluSrcB = 2'b11; e.aluOp = 2'b11; end
            4'd2: begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 2'b11; end
            4'd3: begin e.iorD = 1'b1; e.memRead = 1'b1; end
            4'd4: begin e.memtoReg = 2'b01; e.regWrite = 1'b1; end
            4'd5: begin e.iorD = 1'b1; e.memWrite = 1'b1; end
            4'd6: begin e.aluSrcA = 1'b1; end
            4'd7: begin e.regDst = 2'b01; e.regWrite = 1'b1; end
            4'd8: begin
                e.aluSrcA = 1'b1; e.aluOp = 2'b01; e.pcWriteCond = 1'b1; e.pcSource = 2'b01;
            end
            4'd9: begin e.pcWrite = 1'b1; e.pcSource = 2'b10; end
            4'd10: begin
                e.pcWrite = 1'b1; e.pcSource = 2'b10; e.regDst = 2'b10;
                e.memtoReg = 2'b10; e.regWrite = 1'b1;
            end
            4'd11: begin
                e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
                e.aluOp = (op == 6'h0A) ? 2'b10 : 2'b11;
            end
            4'd12: begin e.regWrite = 1'b1; end
            default: e = '0;
        endcase
        e.fault = flt;
        e.state = st;
        return e;
    endfunction

    task automatic checkOutput();
        obs_t  obs;
        obs_t  exp;
        string tag;
        obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Fault, State};
        exp = expQ.pop_front();
        tag = tagQ.pop_front();
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: queue the expectation, check at the falling edge.
    task automatic applyStimulus(input string tag, input logic [5:0] op, input logic rdy,
                                 input logic [3:0] expState, input logic expFault);
        Opcode   = op;
        MemReady = rdy;
        expQ.push_back(expCtrl(expState, op, rdy, expFault));
        tagQ.push_back(tag);
        @(negedge Clk);
        checkOutput();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        expQ.push_back('0);
        tagQ.push_back(tag);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Reset_n  = 1'b0;
        Opcode   = 6'h00;
        MemReady = 1'b0;
        #2;
        checkReset("reset_state");
        @(posedge Clk); #1;
        checkReset("reset_held_edge");
        Reset_n = 1'b1;

        // sw stalled in MEMWR, then reset lands mid-cycle
        applyStimulus("sw_fetch",     6'h2B, 1'b1, 4'd0, 1'b0);
        applyStimulus("sw_decode",    6'h2B, 1'b1, 4'd1, 1'b0);
        applyStimulus("sw_memadr",    6'h2B, 1'b1, 4'd2, 1'b0);
        applyStimulus("sw_memwr_w0",  6'h2B, 1'b0, 4'd5, 1'b0);
        applyStimulus("sw_memwr_w1",  6'h2B, 1'b0, 4'd5, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        checkReset("reset_async_memwr");
        @(posedge Clk); #1;
        checkReset("reset_memwr_held");
        Reset_n = 1'b1;
        applyStimulus("post_reset_fetch", 6'h08, 1'b0, 4'd0, 1'b0);

        applyStimulus("addi_fetch",   6'h08, 1'b1, 4'd0,  1'b0);
        applyStimulus("addi_decode",  6'h08, 1'b1, 4'd1,  1'b0);
        applyStimulus("addi_immexec", 6'h08, 1'b1, 4'd11, 1'b0);
        applyStimulus("addi_immwb",   6'h08, 1'b1, 4'd12, 1'b0);

        applyStimulus("lw_fetch",     6'h23, 1'b1, 4'd0, 1'b0);
        applyStimulus("lw_decode",    6'h23, 1'b1, 4'd1, 1'b0);
        applyStimulus("lw_memadr",    6'h23, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("lw_memrd_wait%0d", i), 6'h23, 1'b0, 4'd3, 1'b0);
        end
        applyStimulus("lw_memrd_done", 6'h23, 1'b1, 4'd3, 1'b0);
        applyStimulus("lw_memwb",      6'h23, 1'b1, 4'd4, 1'b0);

        applyStimulus("jal_fetch",  6'h03, 1'b1, 4'd0,  1'b0);
        applyStimulus("jal_decode", 6'h03, 1'b1, 4'd1,  1'b0);
        applyStimulus("jal_exec",   6'h03, 1'b1, 4'd10, 1'b0);

        applyStimulus("beq_fetch",  6'h04, 1'b1, 4'd0, 1'b0);
        applyStimulus("beq_decode", 6'h04, 1'b1, 4'd1, 1'b0);
        applyStimulus("beq_branch", 6'h04, 1'b1, 4'd8, 1'b0);

        applyStimulus("unk_fetch",   6'h3F, 1'b1, 4'd0, 1'b0);
        applyStimulus("unk_decode",  6'h3F, 1'b1, 4'd1, 1'b0);
        applyStimulus("unk_exec",    6'h3F, 1'b1, 4'd6, 1'b0);
        applyStimulus("unk_rtypewb", 6'h3F, 1'b1, 4'd7, 1'b0);

        applyStimulus("slti_fetch",   6'h0A, 1'b1, 4'd0,  1'b0);
        applyStimulus("slti_decode",  6'h0A, 1'b1, 4'd1,  1'b0);
        applyStimulus("slti_immexec", 6'h0A, 1'b1, 4'd11, 1'b0);
        applyStimulus("slti_immwb",   6'h0A, 1'b1, 4'd12, 1'b0);

        applyStimulus("rtype_fetch",   6'h00, 1'b1, 4'd0, 1'b0);
        applyStimulus("rtype_decode",  6'h00, 1'b1, 4'd1, 1'b0);
        applyStimulus("rtype_exec",    6'h00, 1'b1, 4'd6, 1'b0);
        applyStimulus("rtype_wb",      6'h00, 1'b1, 4'd7, 1'b0);

        applyStimulus("sw2_fetch",  6'h2B, 1'b1, 4'd0, 1'b0);
        applyStimulus("sw2_decode", 6'h2B, 1'b1, 4'd1, 1'b0);
        applyStimulus("sw2_memadr", 6'h2B, 1'b1, 4'd2, 1'b0);
        applyStimulus("sw2_memwr",  6'h2B, 1'b1, 4'd5, 1'b0);

        // Ready arrives exactly on the limit cycle: no fault
        for (int i = 0; i < 15; i++) begin
            applyStimulus($sformatf("nearmiss_wait%0d", i), 6'h02, 1'b0, 4'd0, 1'b0);
        end
        applyStimulus("nearmiss_fetch_done", 6'h02, 1'b1, 4'd0, 1'b0);
        applyStimulus("nearmiss_decode",     6'h02, 1'b1, 4'd1, 1'b0);
        applyStimulus("nearmiss_jump",       6'h02, 1'b1, 4'd9, 1'b0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("fetch_to_wait%0d", i), 6'h00, 1'b0, 4'd0, 1'b0);
        end
        applyStimulus("fetch_to_halt",        6'h00, 1'b1, 4'd13, 1'b1);
        applyStimulus("fetch_to_halt_sticky", 6'h00, 1'b0, 4'd13, 1'b1);
        applyStimulus("fetch_to_halt_sticky2", 6'h23, 1'b1, 4'd13, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        checkReset("halt_reset_clears");
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        applyStimulus("lwto_fetch",  6'h23, 1'b1, 4'd0, 1'b0);
        applyStimulus("lwto_decode", 6'h23, 1'b1, 4'd1, 1'b0);
        applyStimulus("lwto_memadr", 6'h23, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("lwto_wait%0d", i), 6'h23, 1'b0, 4'd3, 1'b0);
        end
        applyStimulus("lwto_halt", 6'h23, 1'b1, 4'd13, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        checkReset("lwto_reset_clears");
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        applyStimulus("final_fetch", 6'h00, 1'b0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
